gf128_reduce: RTL and testbench
===============================

GF128_REDUCE -- requirements
Module: gf128_reduce

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, output FIFO depth; a power of two, at least 2.
REQ-002 The block SHALL have port clk, input, 1, clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port valid_i, input, 1, product_i valid this cycle; there is no upstream stall.
REQ-005 The block SHALL have port product_i, input, 256, carry-less product; bit n = coefficient of x^n.
REQ-006 The block SHALL have port valid_o, output, 1, result_o holds a valid entry (FIFO not empty).
REQ-007 The block SHALL have port ready_i, input, 1, consumer accepts result_o this cycle.
REQ-008 The block SHALL have port result_o, output, 128, product_i mod P(x) = x^128+x^7+x^2+x+1.
REQ-009 The block SHALL have port count_o, output, log2(DEPTH)+1, FIFO occupancy.
REQ-010 The block SHALL have port overflow_o, output, 1, sticky flag: a result was dropped.

Function
REQ-011 The block SHALL sample product_i on every rising edge where valid_i=1.
REQ-012 Stage 1 SHALL register m[134:0] = lo ^ hi ^ (hi<<1) ^ (hi<<2) ^ (hi<<7), with hi = product_i[255:128] and lo = product_i[127:0], both zero-extended.
REQ-013 Stage 2 SHALL register r = m[127:0] ^ e ^ (e<<1) ^ (e<<2) ^ (e<<7), with e = m[134:128].
REQ-014 Reduction SHALL be correct for all 256-bit inputs, including product_i[255]=1.
REQ-015 A valid bit SHALL travel with each stage; invalid stages SHALL NOT write the FIFO.
REQ-016 The stage 2 result SHALL be pushed into the FIFO one edge after stage 2 captures it.
REQ-017 For an input sampled at edge k into an empty FIFO, valid_o SHALL rise after edge k+3.
REQ-018 With ready_i held high, the block SHALL accept one input per cycle at full throughput.
REQ-019 The FIFO SHALL be first-word fall-through: result_o shows the head entry whenever valid_o=1.
REQ-020 A pop SHALL occur at an edge when valid_o=1 and ready_i=1.
REQ-021 When valid_o=0, ready_i SHALL be ignored, with no pointer or count change.
REQ-022 A simultaneous push and pop SHALL leave count_o unchanged and preserve order; this applies when the FIFO is full.
REQ-023 A push while count_o=DEPTH with no pop SHALL discard the new result, leave the FIFO unchanged and set overflow_o.
REQ-024 overflow_o SHALL remain set until reset.
REQ-025 Pointers SHALL wrap modulo DEPTH, and count_o SHALL never exceed DEPTH.
REQ-026 Results SHALL leave in input order.
REQ-027 result_o SHALL be 0 whenever valid_o=0.

Reset
REQ-028 While rst_n=0, the block SHALL clear all stage valids, pointers, count_o, overflow_o and valid_o immediately, without waiting for clk.
REQ-029 Reset SHALL drive result_o to 0.
REQ-030 A reset asserted mid-stream SHALL discard all in-flight and buffered results; none appear after release.
REQ-031 The first input after release SHALL be sampled at the first rising edge with rst_n=1 and valid_i=1.

Verification
REQ-032 The bench SHALL apply product_i=2^128 (bit 128 only) and require result_o = 0x87.
REQ-033 The bench SHALL apply product_i=2^255 and require result_o = 0x80000000_00000000_00000000_00002049.
REQ-034 The bench SHALL apply product_i with hi=0 and lo=0x0123...CDEF and require result_o = lo unchanged, with valid_o rising exactly 3 edges after sampling.
REQ-035 The bench SHALL stream 10 random products with ready_i=1 and require 10 results in order, each matching a software reference of the polynomial mod P, with count_o never exceeding 1.
REQ-036 The bench SHALL hold ready_i=0 and stream 6 inputs with DEPTH=4, then require count_o=4, overflow_o=1, and that draining yields the first 4 results only.
REQ-037 The bench SHALL fill the FIFO to 4, then apply valid_i=1 and ready_i=1 each cycle, and require count_o to stay at 4 with overflow_o=0; it SHALL then assert rst_n=0 mid-stream and require valid_o=0, count_o=0 and no stale output afterwards.

Source files
------------

// File: rtl/gf128_reduce.sv
// gf128_reduce: two-stage reduction of a 256-bit carry-less product modulo
// P(x) = x^128 + x^7 + x^2 + x + 1, followed by a first-word fall-through
// output FIFO.
//
// Ports
//   clk         clock, all state changes on the rising edge
//   rst_n       asynchronous active-low reset
//   valid_i     product_i is valid this cycle (no upstream stall)
//   product_i   256-bit carry-less product, bit n = coefficient of x^n
//   valid_o     FIFO not empty, result_o holds the head entry
//   ready_i     consumer accepts result_o this cycle
//   result_o    head entry (product mod P), zero while valid_o = 0
//   count_o     FIFO occupancy, 0..DEPTH
//   overflow_o  sticky: a result was dropped because the FIFO was full
//
// Timing: input register (edge k), stage 1 (k+1), stage 2 (k+2),
// FIFO write (k+3), so valid_o rises after edge k+3 into an empty FIFO.
module gf128_reduce #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     valid_i,
    input  logic [255:0]             product_i,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [127:0]             result_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    // Pipeline valids (reset) and data (no reset, loaded only when valid)
    logic         v0_q, v1_q, v2_q;
    logic [255:0] in_q;
    logic [134:0] m_q;
    logic [127:0] r_q;

    logic [127:0] hi, lo;
    logic [134:0] m_d;
    logic [6:0]   e;
    logic [127:0] r_d;

    // Stage 1 folds the upper 128 coefficients once using x^128 = x^7+x^2+x+1;
    // that leaves at most 7 bits above x^127, folded again in stage 2.
    always_comb begin
        hi  = in_q[255:128];
        lo  = in_q[127:0];
        m_d = {7'b0, lo} ^ {7'b0, hi} ^ {6'b0, hi, 1'b0}
            ^ {5'b0, hi, 2'b0} ^ {hi, 7'b0};
        e   = m_q[134:128];
        r_d = m_q[127:0] ^ {121'b0, e} ^ {120'b0, e, 1'b0}
            ^ {119'b0, e, 2'b0} ^ {114'b0, e, 7'b0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0_q <= 1'b0;
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else begin
            v0_q <= valid_i;
            v1_q <= v0_q;
            v2_q <= v1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (valid_i) in_q <= product_i;
        if (v0_q)    m_q  <= m_d;
        if (v1_q)    r_q  <= r_d;
    end

    // Output FIFO
    logic [127:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count_q;
    logic          ovf_q;
    logic          do_pop, do_push, drop;

    always_comb begin
        do_pop  = (count_q != '0) && ready_i;
        // A full FIFO still accepts a push when a pop frees a slot the same edge.
        do_push = v2_q && ((count_q != FULL_CNT) || do_pop);
        drop    = v2_q && (count_q == FULL_CNT) && !do_pop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (drop) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= r_q;
    end

    always_comb begin
        valid_o    = (count_q != '0);
        result_o   = valid_o ? mem[rd_ptr] : '0;
        count_o    = count_q;
        overflow_o = ovf_q;
    end

endmodule

// File: tb/tb_gf128_reduce.sv
// Self-checking bench for gf128_reduce: a queue-based behavioural model
// (long-division reduction, fixed 3-edge latency, bounded FIFO) compared
// against the DUT every falling edge, plus directed literal checks.
module tb_gf128_reduce;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned LAT   = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         valid_i = 1'b0;
    logic [255:0] product_i = '0;
    logic         valid_o;
    logic         ready_i = 1'b0;
    logic [127:0] result_o;
    logic [2:0]   count_o;
    logic         overflow_o;

    int unsigned total = 0;
    int unsigned bad = 0;

    gf128_reduce #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_i    (valid_i),
        .product_i  (product_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .result_o   (result_o),
        .count_o    (count_o),
        .overflow_o (overflow_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Polynomial long division by P(x), one quotient bit at a time.
    function automatic logic [127:0] ref_mod(input logic [255:0] p);
        logic [255:0] t;
        logic [255:0] poly;
        t    = p;
        poly = (256'h1 << 128) | 256'h87;
        for (int i = 255; i >= 128; i--)
            if (t[i]) t = t ^ (poly << (i - 128));
        return t[127:0];
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [127:0] val;
        int unsigned  due;
    } pend_t;

    pend_t        pq[$];
    logic [127:0] mq[$];
    bit           m_ovf = 1'b0;
    int unsigned  cyc = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pq.delete();
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            bit           arr;
            logic [127:0] aval;
            arr  = 1'b0;
            aval = '0;
            if (pq.size() > 0 && pq[0].due == cyc) begin
                arr  = 1'b1;
                aval = pq[0].val;
                void'(pq.pop_front());
            end
            if (mq.size() > 0 && ready_i) void'(mq.pop_front());
            if (arr) begin
                if (mq.size() < DEPTH) mq.push_back(aval);
                else m_ovf = 1'b1;
            end
            if (valid_i) pq.push_back('{val: ref_mod(product_i), due: cyc + LAT});
            cyc++;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        logic [127:0] exp_res;
        exp_res = (mq.size() > 0) ? mq[0] : '0;
        check("valid_o", {255'b0, valid_o}, {255'b0, (mq.size() > 0)});
        check("count_o", {253'b0, count_o}, 256'(mq.size()));
        check("result_o", {128'b0, result_o}, {128'b0, exp_res});
        check("overflow_o", {255'b0, overflow_o}, {255'b0, m_ovf});
    end

    // ---------------- stimulus ----------------
    task automatic apply_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid_o", {255'b0, valid_o}, 256'd0);
        check("rst_count_o", {253'b0, count_o}, 256'd0);
        check("rst_result_o", {128'b0, result_o}, 256'd0);
        check("rst_overflow_o", {255'b0, overflow_o}, 256'd0);
        valid_i = 1'b0;
        ready_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One input into an empty FIFO; valid_o must appear exactly 3 edges later.
    task automatic single(input string name, input logic [255:0] p, input logic [127:0] exp);
        @(negedge clk);
        valid_i   = 1'b1;
        product_i = p;
        ready_i   = 1'b0;
        @(negedge clk);
        valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check({name, "_early"}, {255'b0, valid_o}, 256'd0);
            @(negedge clk);
        end
        check({name, "_valid"}, {255'b0, valid_o}, 256'd1);
        check(name, {128'b0, result_o}, {128'b0, exp});
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        check({name, "_popped"}, {255'b0, valid_o}, 256'd0);
    endtask

    initial begin
        int unsigned pops;
        int unsigned maxc;
        int unsigned n;
        logic [255:0] p;
        logic [127:0] lo_pat;

        lo_pat = 128'h0123456789ABCDEF0123456789ABCDEF;

        // Pin the reference model with hand-derived values.
        p = 256'h1 << 128;
        check("pin_x128", {128'b0, ref_mod(p)}, 256'h87);
        p = 256'h1 << 255;
        check("pin_x255", {128'b0, ref_mod(p)}, {128'b0, 128'h80000000_00000000_00000000_00002049});
        check("pin_lo_only", {128'b0, ref_mod({128'b0, lo_pat})}, {128'b0, lo_pat});

        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        single("x128", 256'h1 << 128, 128'h87);
        single("x255", 256'h1 << 255, 128'h80000000_00000000_00000000_00002049);
        single("lo_only", {128'b0, lo_pat}, lo_pat);

        // Full-throughput stream of 10 random products.
        pops = 0;
        maxc = 0;
        ready_i = 1'b1;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (count_o > maxc) maxc = count_o;
            if (valid_o) pops++;
            valid_i = (i < 10);
            p = rand256();
            if (i == 3) p[255] = 1'b1;
            product_i = p;
        end
        @(negedge clk);
        ready_i = 1'b0;
        check("stream_results", 256'(pops), 256'd10);
        check("stream_max_count", 256'(maxc), 256'd1);

        // Overflow: 6 inputs into a 4-deep FIFO with no consumer.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            valid_i   = 1'b1;
            product_i = rand256();
        end
        @(negedge clk);
        valid_i = 1'b0;
        repeat (4) @(negedge clk);
        check("ovf_count", {253'b0, count_o}, 256'd4);
        check("ovf_flag", {255'b0, overflow_o}, 256'd1);
        pops = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            ready_i = 1'b1;
            if (valid_o) pops++;
        end
        @(negedge clk);
        ready_i = 1'b0;
        check("ovf_drained", 256'(pops), 256'd4);
        check("ovf_sticky", {255'b0, overflow_o}, 256'd1);

        apply_reset();
        check("ovf_cleared", {255'b0, overflow_o}, 256'd0);

        // Fill to 4 while the pipeline stays busy, then push+pop at full.
        n = 0;
        do begin
            @(negedge clk);
            valid_i   = 1'b1;
            product_i = rand256();
            n++;
        end while (count_o != 3'd4 && n < 20);
        check("fill_reached", {253'b0, count_o}, 256'd4);
        ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("full_pushpop_count", {253'b0, count_o}, 256'd4);
            check("full_pushpop_ovf", {255'b0, overflow_o}, 256'd0);
            product_i = rand256();
        end

        // Mid-stream reset: nothing buffered or in flight may reappear.
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("post_rst_valid", {255'b0, valid_o}, 256'd0);
            check("post_rst_count", {253'b0, count_o}, 256'd0);
        end

        p = rand256();
        single("after_reset", p, ref_mod(p));

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
